// File: rtl/dram_port_arbiter.sv
// dram_port_arbiter
//   Shares the single-port data RAM between the CPU data port and the
//   host/loader port. The CPU has priority. A pending host request that
//   keeps losing to the CPU wins once it has lost MAX_WAIT consecutive
//   enabled cycles. Read data from the synchronous RAM (1-cycle latency)
//   is steered back to whichever requester issued the read.
//
//   Ports
//     i_clk, i_rst, i_clk_en       : clock, async active-high reset, clock enable
//     i_cpu_*  / o_cpu_*           : CPU request, stall and read return
//     i_host_* / o_host_*          : host request, grant and read return
//     o_ram_*  / i_ram_dout        : RAM access port
module dram_port_arbiter #(
  parameter int AW       = 24,
  parameter int DW       = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_clk_en,
  input  logic          i_cpu_req,
  input  logic          i_cpu_wr,
  input  logic [AW-1:0] i_cpu_addr,
  input  logic [DW-1:0] i_cpu_wdata,
  output logic          o_cpu_stall,
  output logic [DW-1:0] o_cpu_rdata,
  output logic          o_cpu_rvalid,
  input  logic          i_host_req,
  input  logic          i_host_wr,
  input  logic [AW-1:0] i_host_addr,
  input  logic [DW-1:0] i_host_wdata,
  output logic          o_host_gnt,
  output logic [DW-1:0] o_host_rdata,
  output logic          o_host_rvalid,
  output logic          o_ram_en,
  output logic          o_ram_wr,
  output logic [AW-1:0] o_ram_addr,
  output logic [DW-1:0] o_ram_din,
  input  logic [DW-1:0] i_ram_dout
);

  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

  logic [3:0] wait_q;
  logic [1:0] rd_owner_q;   // bit0: CPU read in flight, bit1: host read in flight
  logic       host_win;
  logic       cpu_win;

  always_comb begin
    host_win = i_host_req & (~i_cpu_req | (wait_q == MAX_WAIT_C));
    cpu_win  = i_cpu_req & ~host_win;
  end

  assign o_cpu_stall = i_cpu_req & (host_win | ~i_clk_en);
  assign o_host_gnt  = host_win & i_clk_en;
  assign o_ram_en    = (cpu_win | host_win) & i_clk_en;

  always_comb begin
    o_ram_wr   = 1'b0;
    o_ram_addr = '0;
    o_ram_din  = '0;
    if (host_win) begin
      o_ram_wr   = i_host_wr & o_ram_en;
      o_ram_addr = i_host_addr;
      o_ram_din  = i_host_wdata;
    end else if (cpu_win) begin
      o_ram_wr   = i_cpu_wr & o_ram_en;
      o_ram_addr = i_cpu_addr;
      o_ram_din  = i_cpu_wdata;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wait_q     <= 4'd0;
      rd_owner_q <= 2'b00;
    end else if (i_clk_en) begin
      if (i_host_req & cpu_win) begin
        if (wait_q != MAX_WAIT_C) wait_q <= wait_q + 4'd1;
      end else begin
        wait_q <= 4'd0;
      end
      rd_owner_q <= {host_win & ~i_host_wr, cpu_win & ~i_cpu_wr};
    end
  end

  // The RAM output is shared; the owner bits decide who sees it as valid.
  assign o_cpu_rvalid  = rd_owner_q[0] & i_clk_en;
  assign o_host_rvalid = rd_owner_q[1] & i_clk_en;
  assign o_cpu_rdata   = i_ram_dout;
  assign o_host_rdata  = i_ram_dout;

  a_rd_owner_onehot : assert property (@(posedge i_clk) disable iff (i_rst) rd_owner_q != 2'b11);

endmodule

// File: tb/tb_dram_port_arbiter.sv
module tb_dram_port_arbiter;
  localparam int AW = 24;
  localparam int DW = 32;

  logic          i_clk, i_rst, i_clk_en;
  logic          i_cpu_req, i_cpu_wr;
  logic [AW-1:0] i_cpu_addr;
  logic [DW-1:0] i_cpu_wdata;
  logic          o_cpu_stall, o_cpu_rvalid;
  logic [DW-1:0] o_cpu_rdata;
  logic          i_host_req, i_host_wr;
  logic [AW-1:0] i_host_addr;
  logic [DW-1:0] i_host_wdata;
  logic          o_host_gnt, o_host_rvalid;
  logic [DW-1:0] o_host_rdata;
  logic          o_ram_en, o_ram_wr;
  logic [AW-1:0] o_ram_addr;
  logic [DW-1:0] o_ram_din;
  logic [DW-1:0] i_ram_dout;

  int n_cmp  = 0;
  int n_fail = 0;

  dram_port_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(4)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_clk_en(i_clk_en),
    .i_cpu_req(i_cpu_req), .i_cpu_wr(i_cpu_wr), .i_cpu_addr(i_cpu_addr),
    .i_cpu_wdata(i_cpu_wdata), .o_cpu_stall(o_cpu_stall), .o_cpu_rdata(o_cpu_rdata),
    .o_cpu_rvalid(o_cpu_rvalid),
    .i_host_req(i_host_req), .i_host_wr(i_host_wr), .i_host_addr(i_host_addr),
    .i_host_wdata(i_host_wdata), .o_host_gnt(o_host_gnt), .o_host_rdata(o_host_rdata),
    .o_host_rvalid(o_host_rvalid),
    .o_ram_en(o_ram_en), .o_ram_wr(o_ram_wr), .o_ram_addr(o_ram_addr),
    .o_ram_din(o_ram_din), .i_ram_dout(i_ram_dout)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Synchronous RAM model: 1-cycle read latency, output held while en is low.
  logic [DW-1:0] mem [0:255];
  always @(posedge i_clk) begin
    if (i_rst) begin
      mem[8'h10] <= 32'hDEADBEEF;
      mem[8'h30] <= 32'hCAFE0001;
    end else if (o_ram_en) begin
      if (o_ram_wr) mem[o_ram_addr[7:0]] <= o_ram_din;
      else          i_ram_dout <= mem[o_ram_addr[7:0]];
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle();
    i_cpu_req = 0; i_cpu_wr = 0; i_cpu_addr = '0; i_cpu_wdata = '0;
    i_host_req = 0; i_host_wr = 0; i_host_addr = '0; i_host_wdata = '0;
  endtask

  task automatic test_reset();
    idle();
    i_clk_en = 1; i_rst = 1;
    i_cpu_req = 1; i_cpu_addr = 24'h10;
    step(); step();
    #1;
    if (o_cpu_rvalid !== 1'b0) begin $display("FAIL rst_cpu_rvalid: got %0h want 0", o_cpu_rvalid); n_fail++; end n_cmp++;
    if (o_host_rvalid !== 1'b0) begin $display("FAIL rst_host_rvalid: got %0h want 0", o_host_rvalid); n_fail++; end n_cmp++;
    if (dut.wait_q !== 4'd0) begin $display("FAIL rst_wait_q: got %0d want 0", dut.wait_q); n_fail++; end n_cmp++;
    if (o_ram_en !== 1'b1) begin $display("FAIL rst_ram_en_comb: got %0h want 1", o_ram_en); n_fail++; end n_cmp++;
    if (o_cpu_stall !== 1'b0) begin $display("FAIL rst_stall: got %0h want 0", o_cpu_stall); n_fail++; end n_cmp++;
    if (o_host_gnt !== 1'b0) begin $display("FAIL rst_host_gnt: got %0h want 0", o_host_gnt); n_fail++; end n_cmp++;
    idle();
    step();
    i_rst = 0;
    step();
  endtask

  task automatic test_cpu_read();
    i_cpu_req = 1; i_cpu_wr = 0; i_cpu_addr = 24'h10;
    #1;
    if (o_ram_en !== 1'b1) begin $display("FAIL cpu_rd_ram_en: got %0h want 1", o_ram_en); n_fail++; end n_cmp++;
    if (o_ram_addr !== 24'h10) begin $display("FAIL cpu_rd_addr: got %0h want 10", o_ram_addr); n_fail++; end n_cmp++;
    if (o_ram_wr !== 1'b0) begin $display("FAIL cpu_rd_wr: got %0h want 0", o_ram_wr); n_fail++; end n_cmp++;
    if (o_cpu_stall !== 1'b0) begin $display("FAIL cpu_rd_stall: got %0h want 0", o_cpu_stall); n_fail++; end n_cmp++;
    step();
    idle();
    #1;
    if (o_cpu_rvalid !== 1'b1) begin $display("FAIL cpu_rd_rvalid: got %0h want 1", o_cpu_rvalid); n_fail++; end n_cmp++;
    if (o_cpu_rdata !== 32'hDEADBEEF) begin $display("FAIL cpu_rd_rdata: got %0h want deadbeef", o_cpu_rdata); n_fail++; end n_cmp++;
    if (o_host_rvalid !== 1'b0) begin $display("FAIL cpu_rd_host_rvalid: got %0h want 0", o_host_rvalid); n_fail++; end n_cmp++;
    step();
    if (o_cpu_rvalid !== 1'b0) begin $display("FAIL cpu_rd_rvalid_clear: got %0h want 0", o_cpu_rvalid); n_fail++; end n_cmp++;
  endtask

  task automatic test_host_write();
    i_host_req = 1; i_host_wr = 1; i_host_addr = 24'h20; i_host_wdata = 32'h12345678;
    #1;
    if (o_host_gnt !== 1'b1) begin $display("FAIL hw_gnt: got %0h want 1", o_host_gnt); n_fail++; end n_cmp++;
    if (o_ram_wr !== 1'b1) begin $display("FAIL hw_ram_wr: got %0h want 1", o_ram_wr); n_fail++; end n_cmp++;
    if (o_ram_din !== 32'h12345678) begin $display("FAIL hw_din: got %0h want 12345678", o_ram_din); n_fail++; end n_cmp++;
    if (o_ram_addr !== 24'h20) begin $display("FAIL hw_addr: got %0h want 20", o_ram_addr); n_fail++; end n_cmp++;
    step();
    idle();
    #1;
    if (o_cpu_rvalid !== 1'b0) begin $display("FAIL hw_cpu_rvalid: got %0h want 0", o_cpu_rvalid); n_fail++; end n_cmp++;
    if (o_host_rvalid !== 1'b0) begin $display("FAIL hw_host_rvalid: got %0h want 0", o_host_rvalid); n_fail++; end n_cmp++;
    if (mem[8'h20] !== 32'h12345678) begin $display("FAIL hw_mem: got %0h want 12345678", mem[8'h20]); n_fail++; end n_cmp++;
    step();
  endtask

  task automatic test_contention();
    i_cpu_req = 1; i_cpu_wr = 0; i_cpu_addr = 24'h10;
    i_host_req = 1; i_host_wr = 0; i_host_addr = 24'h30;
    for (int k = 0; k < 10; k++) begin
      automatic logic [3:0] exp_wait = 4'(k % 5);
      automatic logic exp_hwin = (k % 5 == 4);
      automatic logic prev_hwin = (k > 0) && ((k - 1) % 5 == 4);
      #1;
      if (dut.wait_q !== exp_wait) begin $display("FAIL cont_wait_q k=%0d: got %0d want %0d", k, dut.wait_q, exp_wait); n_fail++; end n_cmp++;
      if (o_host_gnt !== exp_hwin) begin $display("FAIL cont_gnt k=%0d: got %0h want %0h", k, o_host_gnt, exp_hwin); n_fail++; end n_cmp++;
      if (o_cpu_stall !== exp_hwin) begin $display("FAIL cont_stall k=%0d: got %0h want %0h", k, o_cpu_stall, exp_hwin); n_fail++; end n_cmp++;
      if (o_ram_addr !== (exp_hwin ? 24'h30 : 24'h10)) begin $display("FAIL cont_addr k=%0d: got %0h", k, o_ram_addr); n_fail++; end n_cmp++;
      if (k > 0) begin
        if (o_host_rvalid !== prev_hwin) begin $display("FAIL cont_host_rvalid k=%0d: got %0h want %0h", k, o_host_rvalid, prev_hwin); n_fail++; end n_cmp++;
        if (o_cpu_rvalid !== !prev_hwin) begin $display("FAIL cont_cpu_rvalid k=%0d: got %0h want %0h", k, o_cpu_rvalid, !prev_hwin); n_fail++; end n_cmp++;
        if (o_cpu_rdata !== (prev_hwin ? 32'hCAFE0001 : 32'hDEADBEEF)) begin $display("FAIL cont_rdata k=%0d: got %0h", k, o_cpu_rdata); n_fail++; end n_cmp++;
      end
      step();
    end
    idle();
    step();
  endtask

  task automatic test_clk_en();
    i_cpu_req = 1; i_cpu_wr = 0; i_cpu_addr = 24'h10;
    i_host_req = 1; i_host_wr = 0; i_host_addr = 24'h30;
    step(); step();
    i_clk_en = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (o_ram_en !== 1'b0) begin $display("FAIL ce_ram_en i=%0d: got %0h want 0", i, o_ram_en); n_fail++; end n_cmp++;
      if (o_host_gnt !== 1'b0) begin $display("FAIL ce_gnt i=%0d: got %0h want 0", i, o_host_gnt); n_fail++; end n_cmp++;
      if (o_cpu_stall !== 1'b1) begin $display("FAIL ce_stall i=%0d: got %0h want 1", i, o_cpu_stall); n_fail++; end n_cmp++;
      if (o_cpu_rvalid !== 1'b0) begin $display("FAIL ce_rvalid i=%0d: got %0h want 0", i, o_cpu_rvalid); n_fail++; end n_cmp++;
      if (dut.wait_q !== 4'd2) begin $display("FAIL ce_wait_q i=%0d: got %0d want 2", i, dut.wait_q); n_fail++; end n_cmp++;
      step();
    end
    i_clk_en = 1;
    #1;
    if (dut.wait_q !== 4'd2) begin $display("FAIL ce_resume_wait: got %0d want 2", dut.wait_q); n_fail++; end n_cmp++;
    if (o_cpu_rvalid !== 1'b1) begin $display("FAIL ce_resume_rvalid: got %0h want 1", o_cpu_rvalid); n_fail++; end n_cmp++;
    if (o_cpu_rdata !== 32'hDEADBEEF) begin $display("FAIL ce_resume_rdata: got %0h want deadbeef", o_cpu_rdata); n_fail++; end n_cmp++;
    if (o_cpu_stall !== 1'b0) begin $display("FAIL ce_resume_stall: got %0h want 0", o_cpu_stall); n_fail++; end n_cmp++;
    step();
    if (dut.wait_q !== 4'd3) begin $display("FAIL ce_resume_count: got %0d want 3", dut.wait_q); n_fail++; end n_cmp++;
    idle();
    step();
  endtask

  task automatic test_reset_mid();
    i_cpu_req = 1; i_cpu_wr = 0; i_cpu_addr = 24'h10;
    i_host_req = 1; i_host_wr = 0; i_host_addr = 24'h30;
    step();
    idle();
    i_rst = 1;
    #1;
    if (o_cpu_rvalid !== 1'b0) begin $display("FAIL rmid_rvalid: got %0h want 0", o_cpu_rvalid); n_fail++; end n_cmp++;
    if (dut.wait_q !== 4'd0) begin $display("FAIL rmid_wait_q: got %0d want 0", dut.wait_q); n_fail++; end n_cmp++;
    step();
    i_rst = 0;
    step();
    i_cpu_req = 1; i_cpu_addr = 24'h10;
    #1;
    if (o_ram_en !== 1'b1) begin $display("FAIL rmid_reissue_en: got %0h want 1", o_ram_en); n_fail++; end n_cmp++;
    step();
    idle();
    #1;
    if (o_cpu_rvalid !== 1'b1) begin $display("FAIL rmid_reissue_rvalid: got %0h want 1", o_cpu_rvalid); n_fail++; end n_cmp++;
    if (o_cpu_rdata !== 32'hDEADBEEF) begin $display("FAIL rmid_reissue_rdata: got %0h want deadbeef", o_cpu_rdata); n_fail++; end n_cmp++;
    step();
  endtask

  task automatic test_host_abandon();
    i_cpu_req = 1; i_cpu_wr = 0; i_cpu_addr = 24'h10;
    i_host_req = 1; i_host_wr = 0; i_host_addr = 24'h30;
    step(); step();
    i_host_req = 0;
    #1;
    if (dut.wait_q !== 4'd2) begin $display("FAIL abandon_wait_before: got %0d want 2", dut.wait_q); n_fail++; end n_cmp++;
    if (o_host_gnt !== 1'b0) begin $display("FAIL abandon_gnt: got %0h want 0", o_host_gnt); n_fail++; end n_cmp++;
    step();
    if (dut.wait_q !== 4'd0) begin $display("FAIL abandon_wait_after: got %0d want 0", dut.wait_q); n_fail++; end n_cmp++;
    idle();
    step();
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] addrs [4];
    logic [DW-1:0] datas [4];
    addrs = '{24'h10, 24'h30, 24'h20, 24'h10};
    datas = '{32'hDEADBEEF, 32'hCAFE0001, 32'h12345678, 32'hDEADBEEF};
    for (int j = 0; j < 4; j++) begin
      i_cpu_req = 1; i_cpu_wr = 0; i_cpu_addr = addrs[j];
      #1;
      if (o_ram_addr !== addrs[j] || o_cpu_stall !== 1'b0) begin $display("FAIL b2b_issue j=%0d: addr %0h stall %0h want addr %0h stall 0", j, o_ram_addr, o_cpu_stall, addrs[j]); n_fail++; end n_cmp++;
      if (j > 0) begin
        if (o_cpu_rvalid !== 1'b1 || o_cpu_rdata !== datas[j-1]) begin $display("FAIL b2b_ret j=%0d: rvalid %0h rdata %0h want 1 %0h", j, o_cpu_rvalid, o_cpu_rdata, datas[j-1]); n_fail++; end n_cmp++;
      end
      step();
    end
    idle();
    #1;
    if (o_cpu_rvalid !== 1'b1 || o_cpu_rdata !== datas[3]) begin $display("FAIL b2b_last: rvalid %0h rdata %0h want 1 %0h", o_cpu_rvalid, o_cpu_rdata, datas[3]); n_fail++; end n_cmp++;
    step();
  endtask

  initial begin
    test_reset();
    test_cpu_read();
    test_host_write();
    test_contention();
    test_clk_en();
    test_reset_mid();
    test_host_abandon();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/dram_port_arbiter.md
Name: dram_port_arbiter

Overview:
- Shares the single-port data RAM between two requesters: the CPU data port and a host/loader port (RAM preload, debug readback, dump).
- CPU has priority. Host starvation is bounded by a wait counter.
- Routes synchronous RAM read data back to the requester that issued the read.
- Sits in the system between the cpu_0 data interface, the host port and dram_0.

Parameters:
- AW, 24, address width in words.
- DW, 32, data width.
- MAX_WAIT, 4, max consecutive enabled cycles a pending host request loses to the CPU (range 1..15).

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  reset, asynchronous, active-high
- i_clk_en  in  1  clock enable; all state advances only when high
- i_cpu_req  in  1  CPU access request; held while o_cpu_stall is high
- i_cpu_wr  in  1  1 = write, 0 = read
- i_cpu_addr  in  AW  CPU word address
- i_cpu_wdata  in  DW  CPU write data
- o_cpu_stall  out  1  CPU request not accepted this cycle
- o_cpu_rdata  out  DW  read data to CPU
- o_cpu_rvalid  out  1  o_cpu_rdata valid
- i_host_req  in  1  host request; held until o_host_gnt
- i_host_wr  in  1  1 = write, 0 = read
- i_host_addr  in  AW  host word address
- i_host_wdata  in  DW  host write data
- o_host_gnt  out  1  host request accepted this cycle
- o_host_rdata  out  DW  read data to host
- o_host_rvalid  out  1  o_host_rdata valid
- o_ram_en  out  1  RAM access enable
- o_ram_wr  out  1  RAM write strobe
- o_ram_addr  out  AW  RAM address
- o_ram_din  out  DW  RAM write data
- i_ram_dout  in  DW  RAM read data; 1-cycle synchronous latency, held while en is low

Behaviour:
- State: wait_q [3:0] and rd_owner_q [1:0] (bit0 = CPU read pending, bit1 = host read pending). Both reset to 0 asynchronously.
- Arbitration, combinational from inputs and state:
  - host_win = i_host_req & (~i_cpu_req | wait_q == MAX_WAIT)
  - cpu_win = i_cpu_req & ~host_win
- Outputs:
  - o_cpu_stall = i_cpu_req & (host_win | ~i_clk_en)
  - o_host_gnt = host_win & i_clk_en
  - o_ram_en = (cpu_win | host_win) & i_clk_en
- RAM mux: the winner's wr/addr/wdata drive o_ram_wr/o_ram_addr/o_ram_din. o_ram_wr = winner wr & o_ram_en. With no winner, addr/din = 0.
- wait_q update, on an enabled cycle:
  - i_host_req & cpu_win: increment, saturating at MAX_WAIT.
  - host_win or ~i_host_req: clear to 0.
  - i_clk_en low: hold.
- rd_owner_q update, on an enabled cycle: rd_owner_q <= {host_win & ~i_host_wr, cpu_win & ~i_cpu_wr}. Holds when i_clk_en is low.
- Read return:
  - o_cpu_rvalid = rd_owner_q[0] & i_clk_en
  - o_host_rvalid = rd_owner_q[1] & i_clk_en
  - o_cpu_rdata = o_host_rdata = i_ram_dout
  - Latency is 1 enabled cycle after grant.
- rd_owner_q is one-hot or zero; both bits set simultaneously is illegal (assert in sim).
- Back-to-back accesses: a new grant every enabled cycle, with no bubbles. Read return of cycle N overlaps the access of cycle N+1.
- Writes never produce rvalid.
- Reset values:
  - All registered state is 0.
  - o_cpu_rvalid and o_host_rvalid are 0.
  - o_cpu_stall, o_host_gnt and o_ram_en follow the combinational equations above.
- Reset mid-operation: a pending read return is dropped immediately and the requester must reissue. wait_q clears.
- The host deasserting its request before grant is legal; wait_q clears on the next enabled cycle.
- Addresses pass through unchecked. I/O decode (0xFFFFFE stdout, 0xFFFFFF halt) is upstream, not in this block.

Test Plan:
- CPU-only read 0x000010, RAM word 0xDEADBEEF -> o_ram_en=1, addr 0x10, stall 0. Next cycle o_cpu_rvalid=1, rdata 0xDEADBEEF, o_host_rvalid=0.
- Host-only write 0x000020 <- 0x12345678 -> o_host_gnt=1 in the same cycle, o_ram_wr=1, din 0x12345678. No rvalid on either port the following cycle.
- CPU and host requesting continuously, MAX_WAIT=4 -> CPU granted 4 cycles. Host granted on the 5th with o_cpu_stall=1. Pattern repeats with period 5; wait_q sequence 0,1,2,3,4,0.
- Starvation-win cycle with both reading, host addr 0x30 = 0xCAFE0001 -> next cycle o_host_rvalid=1, rdata 0xCAFE0001, o_cpu_rvalid=0. The CPU request is granted on the following cycle.
- i_clk_en low for 3 cycles with wait_q=2 under contention -> o_ram_en=0, o_host_gnt=0, o_cpu_stall=1, wait_q held at 2. Counting resumes at 3 on re-enable.
- i_rst pulsed in the cycle after a CPU read grant -> o_cpu_rvalid=0 immediately, wait_q=0. After release, a CPU-only read 0x10 completes in 1 cycle.
